// File: rtl/fcsr_pkg.sv
// fcsr_pkg
//   Shared definitions for the RV32F fcsr block: CSR addresses, CSR operation
//   and FSM state encodings, the FPU rounding-mode and status types, the
//   float-support selector, and the reserved-rounding-mode check.
package fcsr_pkg;

   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   typedef enum logic [1:0] {
      CSR_RSVD = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100,
      DYN = 3'b111
   } roundmode_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef enum logic {
      RV32FNone = 1'b0,
      RV32F     = 1'b1
   } rvfloat_e;

   // 101/110 are unassigned and 111 (DYN) is not a valid static frm value.
   function automatic logic frm_reserved(input logic [2:0] frm);
      return (frm == 3'b101) || (frm == 3'b110) || (frm == 3'b111);
   endfunction

endpackage

// File: rtl/fcsr_flag_fifo.sv
// fcsr_flag_fifo
//   In-order queue of speculative FPU exception flags.
//   Ports:
//     clk, rst      clock, async active-high reset
//     push_i        write data_i at the tail (accepted if not full, or if
//                   a pop happens in the same cycle)
//     data_i        flags to queue
//     pop_i         drop the head (ignored when empty)
//     flush_i       clear every entry; a same-cycle push is discarded
//     head_o        oldest entry
//     full_o        all entries occupied
//     empty_o       no entries
//     empty_next_o  queue will be empty after this clock edge
module fcsr_flag_fifo
   import fcsr_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push_i,
   input  status_t data_i,
   input  logic    pop_i,
   input  logic    flush_i,
   output status_t head_o,
   output logic    full_o,
   output logic    empty_o,
   output logic    empty_next_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   status_t       mem_q [DEPTH];
   status_t       mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o      = (count_q == '0);
   assign full_o       = (count_q == CW'(DEPTH));
   assign head_o       = mem_q[rd_ptr_q];
   assign empty_next_o = (count_d == '0);

   assign do_pop  = pop_i & ~empty_o;
   // When full, the slot being written is the head that is popping this cycle.
   assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   a_push_full: assert property (@(posedge clk) disable iff (rst)
      !(push_i && full_o && !pop_i && !flush_i));
   a_pop_empty: assert property (@(posedge clk) disable iff (rst)
      !(pop_i && empty_o));

endmodule

// File: rtl/fcsr_state.sv
// fcsr_state
//   Architectural fcsr (frm, fflags) storage. Speculative FPU flags are queued
//   in order and ORed into fflags on retire; CSR accesses to fflags/frm/fcsr
//   wait until the flag queue has drained.
//   Ports:
//     clk, rst                       clock, async active-high reset
//     csr_valid_i/op_i/addr_i/wdata_i  CSR request, held until csr_done_o
//     csr_done_o/rdata_o/illegal_o     one-cycle completion with old value
//     flag_valid_i, flag_i, flag_ready_o  FPU flag push
//     retire_i, flush_i              pop oldest / discard all pending flags
//     frm_o, fflags_o, frm_illegal_o architectural state to the FPU
//   Optional (FCSR_FS_DIRTY_EN): fs_clean_i in, fs_dirty_o out.
module fcsr_state
   import fcsr_pkg::*;
#(
   parameter int unsigned FLAG_DEPTH = 4,
   parameter rvfloat_e    RVF        = RV32FNone
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_valid_i,
   input  logic [1:0]  csr_op_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   output logic        csr_done_o,
   output logic [31:0] csr_rdata_o,
   output logic        csr_illegal_o,
   input  logic        flag_valid_i,
   input  logic [4:0]  flag_i,
   output logic        flag_ready_o,
   input  logic        retire_i,
   input  logic        flush_i,
`ifdef FCSR_FS_DIRTY_EN
   input  logic        fs_clean_i,
   output logic        fs_dirty_o,
`endif
   output logic [2:0]  frm_o,
   output logic [4:0]  fflags_o,
   output logic        frm_illegal_o
);

   localparam logic FP_EN = (RVF != RV32FNone);

   state_e      state_q, state_d;
   logic [2:0]  frm_q, frm_d;
   logic [4:0]  fflags_q, fflags_d;
   logic        done_q, done_d;
   logic [31:0] rdata_q, rdata_d;
   logic        illegal_q, illegal_d;

   status_t     fifo_head;
   logic        fifo_full, fifo_empty, fifo_empty_next;
   logic [4:0]  ret_flags, fflags_ret, fflags_base;
   logic        req_illegal, wr_en, enter;
   logic [7:0]  old8, new8, wd8;

   fcsr_flag_fifo #(.DEPTH(FLAG_DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (flag_valid_i),
      .data_i       (status_t'(flag_i)),
      .pop_i        (retire_i),
      .flush_i      (flush_i),
      .head_o       (fifo_head),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .empty_next_o (fifo_empty_next)
   );

   assign flag_ready_o  = ~fifo_full;
   assign frm_o         = FP_EN ? frm_q : '0;
   assign fflags_o      = FP_EN ? fflags_q : '0;
   assign frm_illegal_o = frm_reserved(frm_o);
   assign csr_done_o    = done_q;
   assign csr_rdata_o   = rdata_q;
   assign csr_illegal_o = illegal_q;

   function automatic logic [31:0] csr_view(input logic [11:0] addr,
                                            input logic [2:0] frm,
                                            input logic [4:0] ff);
      case (addr)
         CSR_FFLAGS: return {27'b0, ff};
         CSR_FRM:    return {29'b0, frm};
         default:    return {24'b0, frm, ff};
      endcase
   endfunction

   always_comb begin
      ret_flags  = (retire_i && !fifo_empty) ? fifo_head : '0;
      fflags_ret = fflags_q | ret_flags;

      req_illegal = !FP_EN
                 || !((csr_addr_i == CSR_FFLAGS) || (csr_addr_i == CSR_FRM)
                      || (csr_addr_i == CSR_FCSR))
                 || (csr_op_i == CSR_RSVD);

      // Write side, evaluated in ACCESS against the pre-retire value so the
      // CSR write lands first and this cycle's retired flags are ORed on top.
      old8 = csr_view(csr_addr_i, frm_q, fflags_q)[7:0];
      wd8  = csr_wdata_i[7:0];
      case (csr_op_e'(csr_op_i))
         CSR_RW:  new8 = wd8;
         CSR_RS:  new8 = old8 | wd8;
         default: new8 = old8 & ~wd8;
      endcase
      wr_en = (state_q == ST_ACCESS) && !illegal_q
           && ((csr_op_i == CSR_RW) || (csr_wdata_i != '0));

      frm_d       = frm_q;
      fflags_base = fflags_q;
      if (wr_en) begin
         case (csr_addr_i)
            CSR_FFLAGS: fflags_base = new8[4:0];
            CSR_FRM:    frm_d       = new8[2:0];
            default: begin
               fflags_base = new8[4:0];
               frm_d       = new8[7:5];
            end
         endcase
      end
      fflags_d = fflags_base | ret_flags;

      state_d   = state_q;
      enter     = 1'b0;
      done_d    = 1'b0;
      rdata_d   = '0;
      illegal_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (csr_valid_i) begin
               if (fifo_empty) enter = 1'b1;
               else            state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!csr_valid_i)         state_d = ST_IDLE;
            else if (fifo_empty_next) enter = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // The read value is the state as it stands after this edge's retire,
      // which is what the ACCESS cycle then writes against.
      if (enter) begin
         state_d   = ST_ACCESS;
         done_d    = 1'b1;
         illegal_d = req_illegal;
         rdata_d   = req_illegal ? '0 : csr_view(csr_addr_i, frm_q, fflags_ret);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         frm_q     <= RNE;
         fflags_q  <= '0;
         done_q    <= 1'b0;
         rdata_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         frm_q     <= frm_d;
         fflags_q  <= fflags_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef FCSR_FS_DIRTY_EN
   logic fs_dirty_q, fs_dirty_d;
   always_comb begin
      fs_dirty_d = fs_dirty_q;
      if (fs_clean_i) fs_dirty_d = 1'b0;
      if (FP_EN && ((ret_flags != '0) || wr_en)) fs_dirty_d = 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fs_dirty_q <= 1'b0;
      else     fs_dirty_q <= fs_dirty_d;
   end
   assign fs_dirty_o = fs_dirty_q;
`endif

endmodule

// File: tb/tb_fcsr_state.sv
module tb_fcsr_state;
   import fcsr_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csr_valid = 1'b0;
   logic [1:0]  csr_op = 2'b00;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wdata = '0;
   logic        csr_done;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        flag_valid = 1'b0;
   logic [4:0]  flag = '0;
   logic        flag_ready;
   logic        retire = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  frm;
   logic [4:0]  fflags;
   logic        frm_illegal;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   fcsr_state #(.FLAG_DEPTH(4), .RVF(RV32F)) dut (
      .clk           (clk),
      .rst           (rst),
      .csr_valid_i   (csr_valid),
      .csr_op_i      (csr_op),
      .csr_addr_i    (csr_addr),
      .csr_wdata_i   (csr_wdata),
      .csr_done_o    (csr_done),
      .csr_rdata_o   (csr_rdata),
      .csr_illegal_o (csr_illegal),
      .flag_valid_i  (flag_valid),
      .flag_i        (flag),
      .flag_ready_o  (flag_ready),
      .retire_i      (retire),
      .flush_i       (flush),
      .frm_o         (frm),
      .fflags_o      (fflags),
      .frm_illegal_o (frm_illegal)
   );

   typedef struct {
      logic       push;
      logic [4:0] flag;
      logic       retire;
      logic       flush;
      logic       exp_ready;
      logic [4:0] exp_fflags;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vecs(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         flag_valid = vecs[i].push;
         flag       = vecs[i].flag;
         retire     = vecs[i].retire;
         flush      = vecs[i].flush;
         tick();
         flag_valid = 1'b0;
         retire     = 1'b0;
         flush      = 1'b0;
         check($sformatf("vec%0d_ready", i), {31'b0, flag_ready}, {31'b0, vecs[i].exp_ready});
         check($sformatf("vec%0d_fflags", i), {27'b0, fflags}, {27'b0, vecs[i].exp_fflags});
      end
   endtask

   // Issues one CSR request, waits (bounded) for done, then lets the ACCESS
   // cycle finish so the write is visible on return.
   task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic ill, output int lat);
      csr_valid = 1'b1;
      csr_op    = op;
      csr_addr  = addr;
      csr_wdata = wd;
      lat = 0;
      rd  = '0;
      ill = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (csr_done) begin
            lat = c;
            rd  = csr_rdata;
            ill = csr_illegal;
            break;
         end
      end
      csr_valid = 1'b0;
      if (lat == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL csr_done_timeout: got no done within 20 cycles, expected done");
      end
      tick();
      check("done_pulse_one_cycle", {31'b0, csr_done}, 32'h0);
   endtask

   logic [31:0] rd;
   logic        ill;
   int          lat;

   initial begin
      vecs[0]  = '{1'b1, 5'h01, 1'b0, 1'b0, 1'b1, 5'h00};
      vecs[1]  = '{1'b1, 5'h04, 1'b0, 1'b0, 1'b1, 5'h00};
      vecs[2]  = '{1'b1, 5'h10, 1'b0, 1'b0, 1'b1, 5'h00};
      vecs[3]  = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h01};
      vecs[4]  = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h05};
      vecs[5]  = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h15};
      vecs[6]  = '{1'b1, 5'h02, 1'b0, 1'b0, 1'b1, 5'h00};
      vecs[7]  = '{1'b1, 5'h08, 1'b0, 1'b0, 1'b1, 5'h00};
      vecs[8]  = '{1'b1, 5'h01, 1'b0, 1'b0, 1'b1, 5'h02};
      vecs[9]  = '{1'b1, 5'h02, 1'b0, 1'b0, 1'b1, 5'h02};
      vecs[10] = '{1'b1, 5'h04, 1'b0, 1'b0, 1'b1, 5'h02};
      vecs[11] = '{1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 5'h02};
      vecs[12] = '{1'b1, 5'h10, 1'b1, 1'b0, 1'b0, 5'h03};
      vecs[13] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h03};
      vecs[14] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h07};
      vecs[15] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h0F};
      vecs[16] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h1F};
      vecs[17] = '{1'b1, 5'h04, 1'b0, 1'b0, 1'b1, 5'h00};
      vecs[18] = '{1'b1, 5'h08, 1'b1, 1'b1, 1'b1, 5'h04};

      // Reset values
      #12;
      check("rst_frm", {29'b0, frm}, 32'h0);
      check("rst_fflags", {27'b0, fflags}, 32'h0);
      check("rst_ready", {31'b0, flag_ready}, 32'h1);
      check("rst_done", {31'b0, csr_done}, 32'h0);
      check("rst_rdata", csr_rdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: read fcsr with RS wdata=0
      csr(CSR_RS, CSR_FCSR, 32'h0, rd, ill, lat);
      check("t1_latency", lat, 32'd1);
      check("t1_rdata", rd, 32'h0);
      check("t1_illegal", {31'b0, ill}, 32'h0);
      check("t1_frm", {29'b0, frm}, 32'h0);
      check("t1_fflags", {27'b0, fflags}, 32'h0);

      // 2: push/retire, then clear bits via RC
      run_vecs(0, 5);
      csr(CSR_RC, CSR_FFLAGS, 32'h05, rd, ill, lat);
      check("t2_rc_rdata", rd, 32'h15);
      check("t2_rc_fflags", {27'b0, fflags}, 32'h10);
      csr(CSR_RW, CSR_FFLAGS, 32'h0, rd, ill, lat);
      check("t2_rw_rdata", rd, 32'h10);
      check("t2_rw_fflags", {27'b0, fflags}, 32'h0);

      // 3: access waits in DRAIN until retire+flush empties the queue
      run_vecs(6, 7);
      csr_valid = 1'b1;
      csr_op    = CSR_RS;
      csr_addr  = CSR_FFLAGS;
      csr_wdata = '0;
      tick();
      check("t3_drain_done0", {31'b0, csr_done}, 32'h0);
      retire = 1'b1;
      tick();
      retire = 1'b0;
      check("t3_retire_done0", {31'b0, csr_done}, 32'h0);
      check("t3_retire_fflags", {27'b0, fflags}, 32'h02);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t3_flush_done", {31'b0, csr_done}, 32'h1);
      check("t3_rdata", csr_rdata, 32'h02);
      csr_valid = 1'b0;
      tick();
      check("t3_after_done", {31'b0, csr_done}, 32'h0);
      check("t3_after_fflags", {27'b0, fflags}, 32'h02);

      // 4: fill, push+retire while full, drain
      run_vecs(8, 16);
      csr(CSR_RW, CSR_FCSR, 32'h0, rd, ill, lat);
      check("t4_fcsr_rdata", rd, 32'h1F);
      check("t4_fcsr_fflags", {27'b0, fflags}, 32'h0);

      // Flush drops a same-cycle push but keeps the same-cycle retire
      run_vecs(17, 18);
      csr(CSR_RS, CSR_FFLAGS, 32'h0, rd, ill, lat);
      check("flush_empty_latency", lat, 32'd1);
      check("flush_rdata", rd, 32'h04);

      // 5: frm writes, reserved mode flag, upper wdata bits ignored
      csr(CSR_RW, CSR_FRM, 32'hFFFF_FFF5, rd, ill, lat);
      check("t5_frm_rdata", rd, 32'h0);
      check("t5_frm", {29'b0, frm}, 32'h5);
      check("t5_frm_illegal", {31'b0, frm_illegal}, 32'h1);
      check("t5_fflags_kept", {27'b0, fflags}, 32'h04);
      csr(CSR_RW, CSR_FCSR, 32'h0E3, rd, ill, lat);
      check("t5_fcsr_rdata", rd, 32'hA4);
      check("t5_fcsr_frm", {29'b0, frm}, 32'h7);
      check("t5_fcsr_fflags", {27'b0, fflags}, 32'h03);

      // Retire during ACCESS: write lands first, then retired flags ORed in
      csr_valid  = 1'b1;
      csr_op     = CSR_RW;
      csr_addr   = CSR_FFLAGS;
      csr_wdata  = 32'h01;
      flag_valid = 1'b1;
      flag       = 5'h08;
      tick();
      check("acc_ret_done", {31'b0, csr_done}, 32'h1);
      check("acc_ret_rdata", csr_rdata, 32'h03);
      flag_valid = 1'b0;
      csr_valid  = 1'b0;
      retire     = 1'b1;
      tick();
      retire = 1'b0;
      check("acc_ret_fflags", {27'b0, fflags}, 32'h09);

      // 6: illegal address and reserved op leave state untouched
      csr(CSR_RW, 12'h004, 32'hFF, rd, ill, lat);
      check("t6_addr_illegal", {31'b0, ill}, 32'h1);
      check("t6_addr_fflags", {27'b0, fflags}, 32'h09);
      check("t6_addr_frm", {29'b0, frm}, 32'h7);
      csr(CSR_RSVD, CSR_FFLAGS, 32'h1F, rd, ill, lat);
      check("t6_op_illegal", {31'b0, ill}, 32'h1);
      check("t6_op_fflags", {27'b0, fflags}, 32'h09);

      // Asynchronous reset while an access sits in DRAIN
      flag_valid = 1'b1;
      flag       = 5'h01;
      tick();
      flag_valid = 1'b0;
      csr_valid  = 1'b1;
      csr_op     = CSR_RS;
      csr_addr   = CSR_FFLAGS;
      csr_wdata  = '0;
      tick();
      check("rst_drain_done0", {31'b0, csr_done}, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_frm", {29'b0, frm}, 32'h0);
      check("arst_fflags", {27'b0, fflags}, 32'h0);
      check("arst_frm_illegal", {31'b0, frm_illegal}, 32'h0);
      check("arst_ready", {31'b0, flag_ready}, 32'h1);
      check("arst_done", {31'b0, csr_done}, 32'h0);
      check("arst_rdata", csr_rdata, 32'h0);
      check("arst_illegal", {31'b0, csr_illegal}, 32'h0);
      csr_valid = 1'b0;
      tick();
      rst = 1'b0;
      csr(CSR_RS, CSR_FCSR, 32'h0, rd, ill, lat);
      check("post_rst_latency", lat, 32'd1);
      check("post_rst_rdata", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
